// File: rtl/if_stage_pkg.sv
// Shared pipeline package: FSM encoding for the fetch stage, default reset PC
// and bubble instruction, plus small PC helpers. The ID stage imports this
// package as well, so the defaults stay consistent across the pipeline.
package if_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,  // request outstanding at PC
    HOLD    = 2'd1,  // word captured while frozen, no request
    DISCARD = 2'd2   // redirected while a request was still in flight
  } if_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;  // wraps modulo 2^32
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst (sync, active-low)
//   flush      : load a bubble (highest priority after reset)
//   hold       : keep current contents
//   load       : capture load_inst / load_pc as a valid instruction
//   instruction, pc_out, inst_valid : register contents
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      inst_d  = NOP_INST;
      pc_d    = 32'h0;
      valid_d = 1'b0;
    end else if (hold) begin
      inst_d  = inst_q;
    end else if (load) begin
      inst_d  = load_inst;
      pc_d    = load_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instruction = inst_q;
  assign pc_out      = pc_q;
  assign inst_valid  = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (FETCH/HOLD/DISCARD),
// hold buffer for words returned while frozen, and the IF/ID register.
// Ports:
//   clk, rst (sync, active-low)
//   freeze, branch_taken, branch_target : pipeline control
//   imem_req, imem_addr, imem_ready, imem_rdata : instruction memory
//   instruction, pc_out, inst_valid : IF/ID register outputs
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Address of the in-flight request while discarding; pc_q already holds
  // the redirect target so a later branch simply overwrites it.
  logic [31:0] discard_addr_q, discard_addr_d;
  logic [31:0] hold_buf_q, hold_buf_d;

  logic        ifid_flush, ifid_hold, ifid_load;
  logic [31:0] ifid_inst;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    discard_addr_d = discard_addr_q;
    hold_buf_d     = hold_buf_q;
    ifid_flush     = 1'b0;
    ifid_hold      = 1'b0;
    ifid_load      = 1'b0;
    ifid_inst      = imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d       = align_word(branch_target);
          ifid_flush = 1'b1;
          hold_buf_d = 32'h0;
          if (!imem_ready) begin
            state_d        = DISCARD;
            discard_addr_d = pc_q;
          end
        end else if (imem_ready && freeze) begin
          hold_buf_d = imem_rdata;
          state_d    = HOLD;
          ifid_hold  = 1'b1;
        end else if (imem_ready) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4(pc_q);
        end else if (!freeze) begin
          ifid_flush = 1'b1;
        end else begin
          ifid_hold = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d       = align_word(branch_target);
          ifid_flush = 1'b1;
          hold_buf_d = 32'h0;
          state_d    = FETCH;
        end else if (freeze) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_load = 1'b1;
          ifid_inst = hold_buf_q;
          pc_d      = pc_plus4(pc_q);
          state_d   = FETCH;
        end
      end
      DISCARD: begin
        if (branch_taken) begin
          pc_d       = align_word(branch_target);
          ifid_flush = 1'b1;
        end else if (freeze) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
        // The returned word belongs to the abandoned path.
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      discard_addr_q <= 32'h0;
      hold_buf_q     <= 32'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      discard_addr_q <= discard_addr_d;
      hold_buf_q     <= hold_buf_d;
    end
  end

  assign imem_req  = (state_q != HOLD);
  assign imem_addr = (state_q == DISCARD) ? discard_addr_q : pc_q;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (ifid_flush),
    .hold        (ifid_hold),
    .load        (ifid_load),
    .load_inst   (ifid_inst),
    .load_pc     (pc_plus4(pc_q)),
    .instruction (instruction),
    .pc_out      (pc_out),
    .inst_valid  (inst_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table for the main pipeline flow and
// hand-written sequences for wrap-around, repeated redirect and reset.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (TB_NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .inst_valid    (inst_valid)
  );

  // Memory model: fixed words at 0/4/8, address-derived elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return a + 32'h1000_0000;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        fr;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] e_inst;
    logic [31:0] e_pc_out;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_req;
    if_state_e   e_state;
  } vec_t;

  vec_t vecs[19];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic fr, input logic br,
                       input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    rst           = r;
    freeze        = fr;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_inst,
                           input logic [31:0] e_pc_out, input logic e_valid,
                           input logic [31:0] e_addr, input logic e_req,
                           input if_state_e e_state);
    check32({tag, "_inst"},  instruction, e_inst);
    check32({tag, "_pcout"}, pc_out, e_pc_out);
    check32({tag, "_valid"}, 32'(inst_valid), 32'(e_valid));
    check32({tag, "_addr"},  imem_addr, e_addr);
    check32({tag, "_req"},   32'(imem_req), 32'(e_req));
    check32({tag, "_state"}, 32'(dut.state_q), 32'(e_state));
    $display("%s: addr=%h req=%0d inst=%h pc_out=%h valid=%0d", tag,
             imem_addr, imem_req, instruction, pc_out, inst_valid);
  endtask

  initial begin
    //               fr    br    tgt           rdy   inst           pc_out        v     addr          req   state
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h11,        32'h4,        1'b1, 32'h4,        1'b1, FETCH};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h22,        32'h8,        1'b1, 32'h8,        1'b1, FETCH};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h22,        32'h8,        1'b1, 32'h8,        1'b0, HOLD};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h22,        32'h8,        1'b1, 32'h8,        1'b0, HOLD};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h22,        32'h8,        1'b1, 32'h8,        1'b0, HOLD};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h33,        32'hC,        1'b1, 32'hC,        1'b1, FETCH};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1000_000C, 32'h10,       1'b1, 32'h10,       1'b1, FETCH};
    vecs[7]  = '{1'b0, 1'b1, 32'h40,       1'b0, TB_NOP,        32'h0,        1'b0, 32'h10,       1'b1, DISCARD};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, TB_NOP,        32'h0,        1'b0, 32'h10,       1'b1, DISCARD};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, TB_NOP,        32'h0,        1'b0, 32'h40,       1'b1, FETCH};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1000_0040, 32'h44,       1'b1, 32'h44,       1'b1, FETCH};
    vecs[11] = '{1'b1, 1'b1, 32'h100,      1'b1, TB_NOP,        32'h0,        1'b0, 32'h100,      1'b1, FETCH};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, TB_NOP,        32'h0,        1'b0, 32'h100,      1'b1, FETCH};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1000_0100, 32'h104,      1'b1, 32'h104,      1'b1, FETCH};
    vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h1000_0100, 32'h104,      1'b1, 32'h104,      1'b1, FETCH};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b0, TB_NOP,        32'h0,        1'b0, 32'h104,      1'b1, FETCH};
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, TB_NOP,        32'h0,        1'b0, 32'h104,      1'b0, HOLD};
    vecs[17] = '{1'b1, 1'b1, 32'h203,      1'b0, TB_NOP,        32'h0,        1'b0, 32'h200,      1'b1, FETCH};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1000_0200, 32'h204,      1'b1, 32'h204,      1'b1, FETCH};

    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b0;

    // Reset with a pending branch/freeze: reset wins.
    apply(1'b0, 1'b1, 1'b1, 32'h500, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 32'h0,   1'b0);
    check_all("reset", TB_NOP, 32'h0, 1'b0, 32'h0, 1'b1, FETCH);

    for (int i = 0; i < 19; i++) begin
      apply(1'b1, vecs[i].fr, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_pc_out,
                vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_req, vecs[i].e_state);
    end

    // PC wrap-around: redirect to 0xFFFFFFFF (low bits masked) then fetch.
    apply(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    check_all("wrap_redirect", TB_NOP, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1, FETCH);
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_all("wrap_fetch", 32'h0FFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b1, FETCH);

    // Two redirects while the old request is outstanding: last target wins.
    apply(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
    check_all("dbl_br1", TB_NOP, 32'h0, 1'b0, 32'h0, 1'b1, DISCARD);
    apply(1'b1, 1'b0, 1'b1, 32'h90, 1'b0);
    check_all("dbl_br2", TB_NOP, 32'h0, 1'b0, 32'h0, 1'b1, DISCARD);
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_all("dbl_done", TB_NOP, 32'h0, 1'b0, 32'h90, 1'b1, FETCH);

    // Reset while discarding abandons the request.
    apply(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
    check_all("rst_disc_enter", TB_NOP, 32'h0, 1'b0, 32'h90, 1'b1, DISCARD);
    apply(1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
    check_all("rst_disc", TB_NOP, 32'h0, 1'b0, 32'h0, 1'b1, FETCH);
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_all("rst_first_fetch", 32'h11, 32'h4, 1'b1, 32'h4, 1'b1, FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
